ccd_capture_ctrl: RTL

Sensor-side capture stage of the camera pipeline. It sits directly upstream of the Bayer-to-RGB image processor and converts raw sensor frame/line-valid strobes and 12-bit pixel data into a qualified pixel stream with X/Y coordinates. The image processor consumes this stream on its pixel-data, data-valid and X/Y coordinate inputs. A run-control pair (start/end) gates capture on whole-frame boundaries, and a frame counter reports completed capture starts.

---
 rtl/ccd_capture_ctrl.sv | 64 ++++++
 1 files changed

// File: rtl/ccd_capture_ctrl.sv
// ccd_capture_ctrl: qualifies raw sensor FVAL/LVAL/pixel strobes into a valid pixel stream with X/Y coordinates,
// gating capture on whole-frame boundaries under start/end run control.
module ccd_capture_ctrl #(
  parameter int COLUMN_WIDTH = 1280
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iDATA,
  input  logic        iFVAL,
  input  logic        iLVAL,
  input  logic        iSTART,
  input  logic        iEND,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic [31:0] oFrame_Cont
);
  localparam logic [10:0] xLast = 11'(COLUMN_WIDTH - 1);
  logic        run, fa, faN;
  logic        s1Fval, s1FvalP, s1Lval;
  logic [11:0] s1Data;
  logic [10:0] nx, ny;
  // A frame is only entered on an FVAL rising edge while armed; it always runs to the FVAL fall.
  assign faN = s1Fval & (fa | (~s1FvalP & run));
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      run         <= 1'b0;
      fa          <= 1'b0;
      s1Fval      <= 1'b0;
      s1FvalP     <= 1'b0;
      s1Lval      <= 1'b0;
      s1Data      <= '0;
      nx          <= '0;
      ny          <= '0;
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oFrame_Cont <= '0;
    end else begin
      run     <= iEND ? 1'b0 : (iSTART | run);
      s1Data  <= iDATA;
      s1Lval  <= iLVAL;
      s1Fval  <= iFVAL;
      s1FvalP <= s1Fval;
      fa      <= faN;
      oDATA   <= s1Data;
      oDVAL   <= faN & s1Lval;
      if (!faN) begin
        nx      <= '0;
        ny      <= '0;
        oX_Cont <= '0;
        oY_Cont <= '0;
      end else if (s1Lval) begin
        oX_Cont <= nx;
        oY_Cont <= ny;
        nx      <= (nx == xLast) ? 11'd0 : nx + 11'd1;
        ny      <= (nx == xLast) ? ny + 11'd1 : ny;
      end
      if (faN & ~fa) oFrame_Cont <= oFrame_Cont + 32'd1;
    end
  end
endmodule
